// File: rtl/rr_arbiter_8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_8_pkg
//  Description : Shared definitions for the 8-way round-robin arbiter:
//                requester count, index width, FSM state encoding and the
//                rotating-priority winner search.
//  Revision    : 1.0 - initial release
// ============================================================================
package rr_arbiter_8_pkg;

    localparam int c_N_REQ = 8;
    localparam int c_IDX_W = 3;

    // IDLE: no grant, BUSY: grant held, GAP: one-cycle bus turnaround
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    // Returns the first requester at or after i_ptr (wrapping modulo 8).
    // The request vector is doubled and shifted so the search always starts
    // at bit 0; the lowest set bit of the shifted window is the winner's
    // distance from the pointer. The caller only uses the result when at
    // least one request is present.
    function automatic logic [c_IDX_W-1:0] rr_pick(
        input logic [c_N_REQ-1:0] i_req,
        input logic [c_IDX_W-1:0] i_ptr
    );
        logic [2*c_N_REQ-1:0] v_dbl;
        logic [c_IDX_W-1:0]   v_pick;
        v_dbl  = {i_req, i_req} >> i_ptr;
        v_pick = i_ptr;
        // Descending scan so the closest requester is written last and wins
        for (int k = c_N_REQ - 1; k >= 0; k--) begin
            if (v_dbl[k]) begin
                v_pick = i_ptr + c_IDX_W'(k);
            end
        end
        return v_pick;
    endfunction

endpackage : rr_arbiter_8_pkg
`default_nettype wire

// File: rtl/rr_arbiter_8_grant_dec_38.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_8_grant_dec_38
//  Description : Combinational 3-to-8 decoder with enable. Produces the
//                one-hot, active-high grant vector; all-zero when disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_8_grant_dec_38
    import rr_arbiter_8_pkg::*;
(
    input  logic [c_IDX_W-1:0] i_idx,
    input  logic               i_en,
    output logic [c_N_REQ-1:0] o_onehot
);

    // One comparator per output line; at most one can match a given index
    genvar g;
    generate
        for (g = 0; g < c_N_REQ; g++) begin : g_dec
            assign o_onehot[g] = i_en && (i_idx == c_IDX_W'(g));
        end
    endgenerate

endmodule : rr_arbiter_8_grant_dec_38
`default_nettype wire

// File: rtl/rr_arbiter_8.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_8
//  Description : Round-robin arbiter for 8 requesters. Grants one master at a
//                time, holds the grant until release or HOLD_MAX expiry,
//                inserts one turnaround cycle, then rotates priority to the
//                master after the last winner.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int HOLD_MAX = 16     // legal range 2..255
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               arb_en,
    input  logic [c_N_REQ-1:0] req,
    output logic [c_N_REQ-1:0] grant,
    output logic [c_IDX_W-1:0] grant_idx,
    output logic               grant_vld,
    output logic               timeout
);

    // Last hold count value before a grant must be revoked
    localparam logic [7:0] c_HOLD_LAST = 8'(HOLD_MAX - 1);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    arb_state_t           r_state;
    logic [c_IDX_W-1:0]   r_ptr;
    logic [7:0]           r_hold_cnt;
    logic [c_IDX_W-1:0]   r_idx;
    logic                 r_vld;
    logic                 r_timeout;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    arb_state_t           w_state_nxt;
    logic [c_IDX_W-1:0]   w_ptr_nxt;
    logic [7:0]           w_hold_nxt;
    logic [c_IDX_W-1:0]   w_idx_nxt;
    logic                 w_vld_nxt;
    logic                 w_timeout_nxt;

    logic [c_IDX_W-1:0]   w_winner;
    logic                 w_any_req;
    logic                 w_owner_req;
    logic                 w_can_grant;

    assign w_winner    = rr_pick(req, r_ptr);
    assign w_any_req   = |req;
    assign w_owner_req = req[r_idx];
    assign w_can_grant = arb_en && w_any_req;

    // Next-state and output decode; every target defaults to hold / idle
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold_cnt;
        w_idx_nxt     = r_idx;
        w_vld_nxt     = r_vld;
        w_timeout_nxt = 1'b0;

        case (r_state)
            // IDLE and GAP evaluate new requests identically; GAP exists only
            // so that a grant can never start on the edge another one ends
            ST_IDLE, ST_GAP: begin
                if (w_can_grant) begin
                    w_state_nxt = ST_BUSY;
                    w_idx_nxt   = w_winner;
                    w_vld_nxt   = 1'b1;
                    w_hold_nxt  = 8'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_vld_nxt   = 1'b0;
                end
            end

            // arb_en is deliberately ignored here: a live grant always runs
            // to release or expiry. Release takes precedence over expiry so
            // a master dropping its request on the last cycle sees no pulse.
            ST_BUSY: begin
                if (!w_owner_req) begin
                    w_state_nxt = ST_GAP;
                    w_vld_nxt   = 1'b0;
                    w_ptr_nxt   = r_idx + 1'b1;
                    w_hold_nxt  = 8'd0;
                end else if (r_hold_cnt == c_HOLD_LAST) begin
                    w_state_nxt   = ST_GAP;
                    w_vld_nxt     = 1'b0;
                    w_ptr_nxt     = r_idx + 1'b1;
                    w_hold_nxt    = 8'd0;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_hold_nxt = r_hold_cnt + 8'd1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_vld_nxt   = 1'b0;
                w_hold_nxt  = 8'd0;
            end
        endcase
    end

    // State register with synchronous reset; reset drops any live grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_hold_cnt <= 8'd0;
            r_idx      <= '0;
            r_vld      <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_idx      <= w_idx_nxt;
            r_vld      <= w_vld_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    // One-hot select lines derived from the registered index and valid
    rr_arbiter_8_grant_dec_38 u_grant_dec (
        .i_idx    (r_idx),
        .i_en     (r_vld),
        .o_onehot (grant)
    );

    assign grant_idx = r_idx;
    assign grant_vld = r_vld;
    assign timeout   = r_timeout;

endmodule : rr_arbiter_8
`default_nettype wire

// File: tb/tb_rr_arbiter_8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter_8
//  Description : Self-checking bench for rr_arbiter_8: directed vector table,
//                multi-cycle corner sequences and random traffic against a
//                cycle-level reference model of the arbitration rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_8;

    localparam int HOLD = 16;

    logic       clk;
    logic       rst;
    logic       arb_en;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_vld;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the resource, for how many cycles so far,
    // the last winner, and where the next priority search starts
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = 0;
    int m_ptr   = 0;
    bit m_to    = 0;

    rr_arbiter_8 #(.HOLD_MAX(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .arb_en    (arb_en),
        .req       (req),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       en;
        logic [7:0] q;
        logic [7:0] g;
        logic [2:0] idx;
        logic       vld;
        logic       to;
    } vec_t;

    task automatic model_update(input logic r, input logic e, input logic [7:0] q);
        m_to = 0;
        if (r) begin
            m_owner = -1; m_held = 0; m_last = 0; m_ptr = 0;
        end else if (m_owner >= 0) begin
            if (!q[m_owner]) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
            end else if (m_held == HOLD) begin
                m_to    = 1;
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
            end else begin
                m_held++;
            end
        end else if (e && q != 8'h00) begin
            for (int k = 0; k < 8; k++) begin
                if (q[(m_ptr + k) % 8]) begin
                    m_owner = (m_ptr + k) % 8;
                    break;
                end
            end
            m_held = 1;
            m_last = m_owner;
        end
    endtask

    task automatic check_model(input string nm);
        logic [7:0] eg;
        eg = 8'h00;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        n_checks++;
        if (grant !== eg || grant_idx !== 3'(m_last) || grant_vld !== (m_owner >= 0) ||
            timeout !== m_to) begin
            n_fail++;
            $display("FAIL model/%s t=%0t: got grant=%h idx=%0d vld=%b to=%b, want grant=%h idx=%0d vld=%b to=%b",
                     nm, $time, grant, grant_idx, grant_vld, timeout, eg, m_last, m_owner >= 0, m_to);
        end
    endtask

    task automatic expect_out(input string nm, input logic [7:0] g, input logic [2:0] idx,
                              input logic v, input logic t);
        n_checks++;
        if (grant !== g || grant_idx !== idx || grant_vld !== v || timeout !== t) begin
            n_fail++;
            $display("FAIL %s t=%0t: got grant=%h idx=%0d vld=%b to=%b, want grant=%h idx=%0d vld=%b to=%b",
                     nm, $time, grant, grant_idx, grant_vld, timeout, g, idx, v, t);
        end
    endtask

    // Apply inputs away from the edge, clock once, then check against the model
    task automatic step(input string nm, input logic r, input logic e, input logic [7:0] q);
        @(negedge clk);
        rst = r; arb_en = e; req = q;
        @(posedge clk);
        #1;
        model_update(r, e, q);
        check_model(nm);
    endtask

    vec_t vecs[$];

    initial begin
        logic [7:0] oh;
        logic [7:0] rq;
        int         div;

        rst = 1'b1; arb_en = 1'b0; req = 8'h00;

        // Reset, single request, arb_en low mid-grant, reset mid-grant
        vecs.push_back('{1'b1, 1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hFF, 8'h10, 3'd4, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'hFF, 8'h10, 3'd4, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'hFF, 8'h10, 3'd4, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'hEF, 8'h00, 3'd4, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'hFF, 8'h00, 3'd4, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'hFF, 8'h00, 3'd4, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hFF, 8'h20, 3'd5, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hFE, 8'h00, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0});

        foreach (vecs[i]) begin
            step("table", vecs[i].r, vecs[i].en, vecs[i].q);
            expect_out($sformatf("vec%0d", i), vecs[i].g, vecs[i].idx, vecs[i].vld, vecs[i].to);
        end

        // Rotation: all request, each winner releases after two grant cycles
        step("rot_rst", 1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < 8; i++) begin
            oh = 8'h01 << i;
            step("rot", 1'b0, 1'b1, 8'hFF);
            expect_out($sformatf("rot%0d_a", i), oh, 3'(i), 1'b1, 1'b0);
            step("rot", 1'b0, 1'b1, 8'hFF);
            expect_out($sformatf("rot%0d_b", i), oh, 3'(i), 1'b1, 1'b0);
            step("rot", 1'b0, 1'b1, 8'hFF & ~oh);
            expect_out($sformatf("rot%0d_gap", i), 8'h00, 3'(i), 1'b0, 1'b0);
        end
        step("rot", 1'b0, 1'b1, 8'hFF);
        expect_out("rot_wrap", 8'h01, 3'd0, 1'b1, 1'b0);

        // Timeout: masters 0 and 5 never release
        step("to_rst", 1'b1, 1'b1, 8'h21);
        for (int r = 0; r < 2; r++) begin
            oh = (r == 0) ? 8'h01 : 8'h20;
            for (int c = 0; c < HOLD; c++) begin
                step("to", 1'b0, 1'b1, 8'h21);
                expect_out($sformatf("to_r%0d_c%0d", r, c), oh, (r == 0) ? 3'd0 : 3'd5, 1'b1, 1'b0);
            end
            step("to", 1'b0, 1'b1, 8'h21);
            expect_out($sformatf("to_r%0d_pulse", r), 8'h00, (r == 0) ? 3'd0 : 3'd5, 1'b0, 1'b1);
        end
        step("to", 1'b0, 1'b1, 8'h21);
        expect_out("to_back_to_0", 8'h01, 3'd0, 1'b1, 1'b0);

        // Release on the same cycle the hold limit is reached
        step("sim_rst", 1'b1, 1'b1, 8'h00);
        for (int c = 0; c < HOLD; c++) begin
            step("sim", 1'b0, 1'b1, 8'h04);
            expect_out($sformatf("sim_c%0d", c), 8'h04, 3'd2, 1'b1, 1'b0);
        end
        step("sim", 1'b0, 1'b1, 8'h00);
        expect_out("sim_release", 8'h00, 3'd2, 1'b0, 1'b0);
        step("sim", 1'b0, 1'b1, 8'h00);
        expect_out("sim_after", 8'h00, 3'd2, 1'b0, 1'b0);

        // Random traffic: sticky requests so some grants run to expiry
        rq = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            div = (n < 1500) ? 8 : 40;
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, div - 1) == 0) rq[b] = ~rq[b];
            end
            step("rand", ($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0), rq);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end, got stuck at t=%0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_rr_arbiter_8
`default_nettype wire
